and_mux_pipe_array: RTL and testbench

- Parametrised, pipelined successor to the single-bit mux-based AND fixtures.
- LANES independent WIDTH-bit lanes. Every bit of every lane is built as an explicit 2:1 mux with a constant on one arm. MODE selects the correct "and" form or one of the two wrong-constant forms.
- The mux results pass through an elastic valid/ready pipeline of STAGES registers, plus a saturating transfer counter.
- Serves as a sequential pattern-matching fixture: the mux cones sit between pipeline registers.

---
 rtl/and_mux_pkg.sv | 30 +++
 rtl/and_mux_lane.sv | 38 +++
 rtl/and_mux_pipe_array.sv | 118 +++++++++++
 tb/tb_and_mux_pipe_array.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/and_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : and_mux_pkg
//  Purpose  : Shared constants and helpers for the and_mux_pipe_array fixture.
//             Encodes the three mux "and" forms. Provides the constant arm K
//             for each form and a legality check that the top module applies
//             at elaboration.
//  Ports    : (package, no ports)
//  Revision : 1.0  initial release
// ============================================================================
package and_mux_pkg;

  // Mux forms selectable through the MODE parameter.
  localparam int MODE_GOOD     = 0;  // y = a ? b : 0  (correct AND)
  localparam int MODE_BAD_ONE  = 1;  // y = a ? b : 1  (wrong constant)
  localparam int MODE_BAD_SWAP = 2;  // y = a ? 0 : b  (arms swapped)

  // Constant arm K of the per-bit mux. Only MODE_BAD_ONE uses a 1.
  function automatic logic mode_const(input int mode);
    return (mode == MODE_BAD_ONE) ? 1'b1 : 1'b0;
  endfunction

  // True for the three supported mux forms.
  function automatic bit mode_legal(input int mode);
    return (mode == MODE_GOOD) || (mode == MODE_BAD_ONE) ||
           (mode == MODE_BAD_SWAP);
  endfunction

endpackage : and_mux_pkg
`default_nettype wire

// File: rtl/and_mux_lane.sv
`default_nettype none
// ============================================================================
//  Module   : and_mux_lane
//  Purpose  : One WIDTH-bit lane of per-bit 2:1 muxes. Every mux has a
//             constant on one arm. This block is purely combinational.
//  Ports    : a  in  WIDTH  select operand (one select per bit)
//             b  in  WIDTH  data operand
//             y  out WIDTH  mux result
//  Revision : 1.0  initial release
// ============================================================================
module and_mux_lane
  import and_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = MODE_GOOD
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam logic C_K = mode_const(MODE);

  // Each bit is coded as a ternary so the mux-with-constant structure
  // survives into the netlist rather than collapsing into an AND/OR gate
  // in the source.
  if (MODE == MODE_BAD_SWAP) begin : g_swap
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign y[i] = a[i] ? C_K : b[i];
    end
  end else begin : g_std
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign y[i] = a[i] ? b[i] : C_K;
    end
  end

endmodule : and_mux_lane
`default_nettype wire

// File: rtl/and_mux_pipe_array.sv
`default_nettype none
// ============================================================================
//  Module   : and_mux_pipe_array
//  Purpose  : LANES independent lanes of per-bit constant-arm muxes. The mux
//             results feed an elastic valid/ready pipeline of STAGES
//             registers. A saturating 16-bit counter tracks output handshakes.
//  Ports    : clk         in   1            rising-edge clock
//             reset       in   1            synchronous active-high reset
//             in_valid    in   1            input beat valid
//             in_ready    out  1            pipeline can take a beat
//             in_a        in   LANES*WIDTH  select operands, lane L at [L*WIDTH +: WIDTH]
//             in_b        in   LANES*WIDTH  data operands, same packing
//             out_valid   out  1            output beat valid (registered)
//             out_ready   in   1            downstream accepts the beat
//             out_y       out  LANES*WIDTH  result (registered), same packing
//             xfer_count  out  16           saturating output handshake count
//  Revision : 1.0  initial release
// ============================================================================
module and_mux_pipe_array
  import and_mux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LANES  = 2,
  parameter int STAGES = 2,
  parameter int MODE   = MODE_GOOD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_y,
  output logic [15:0]            xfer_count
);

  localparam int          C_DW      = LANES * WIDTH;
  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  // Reject unsupported mux forms at elaboration time.
  if (!mode_legal(MODE)) begin : g_mode_illegal
    $error("and_mux_pipe_array: illegal MODE %0d", MODE);
  end

  // --------------------------------------------------------------------------
  // Combinational mux array, one sub-block per lane
  // --------------------------------------------------------------------------
  logic [C_DW-1:0] w_mux;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    and_mux_lane #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_lane (
      .a (in_a [l*WIDTH +: WIDTH]),
      .b (in_b [l*WIDTH +: WIDTH]),
      .y (w_mux[l*WIDTH +: WIDTH])
    );
  end

  // --------------------------------------------------------------------------
  // Elastic pipeline
  // --------------------------------------------------------------------------
  logic [STAGES-1:0] r_valid;
  logic [C_DW-1:0]   r_data [STAGES];
  logic [15:0]       r_count;
  logic [STAGES-1:0] w_adv;

  // A stage may advance if the output is being taken or if any stage at or
  // after it is empty. The chain is walked from the output end with a running
  // "all full so far" term. This avoids a vector that depends on its own bits.
  always_comb begin
    logic full_tail;
    w_adv     = '0;
    full_tail = 1'b1;
    for (int s = STAGES - 1; s >= 0; s--) begin
      full_tail = full_tail & r_valid[s];
      w_adv[s]  = out_ready | ~full_tail;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_data[s] <= '0;
      end
      r_count <= '0;
    end else begin
      // Stage 0 data loads only with a real beat. This keeps out_y at zero
      // after reset until the first beat arrives.
      if (w_adv[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_mux;
        end
      end
      for (int s = 1; s < STAGES; s++) begin
        if (w_adv[s]) begin
          r_valid[s] <= r_valid[s-1];
          r_data[s]  <= r_data[s-1];
        end
      end
      if (r_valid[STAGES-1] && out_ready && (r_count != C_CNT_MAX)) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign in_ready   = w_adv[0];
  assign out_valid  = r_valid[STAGES-1];
  assign out_y      = r_data[STAGES-1];
  assign xfer_count = r_count;

endmodule : and_mux_pipe_array
`default_nettype wire

// File: tb/tb_and_mux_pipe_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_and_mux_pipe_array
//  Purpose  : Directed self-checking bench. It runs three DUT instances
//             (MODE 0/1/2) from shared stimulus. Outputs are sampled and
//             inputs are driven on the falling clock edge.
//  Ports    : (none)
//  Revision : 1.0  initial release
// ============================================================================
module tb_and_mux_pipe_array;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_ready;

  logic          rdy0, rdy1, rdy2;
  logic          ov0, ov1, ov2;
  logic [DW-1:0] y0, y1, y2;
  logic [15:0]   cnt0, cnt1, cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  and_mux_pipe_array #(.WIDTH(8), .LANES(2), .STAGES(2), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .out_valid(ov0), .out_ready(out_ready),
    .out_y(y0), .xfer_count(cnt0));

  and_mux_pipe_array #(.WIDTH(8), .LANES(2), .STAGES(2), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .out_valid(ov1), .out_ready(out_ready),
    .out_y(y1), .xfer_count(cnt1));

  and_mux_pipe_array #(.WIDTH(8), .LANES(2), .STAGES(2), .MODE(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .out_valid(ov2), .out_ready(out_ready),
    .out_y(y2), .xfer_count(cnt2));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    cyc(); cyc();

    // Reset state
    chk("rst_ov",   32'(ov0),  32'd0);
    chk("rst_y0",   32'(y0),   32'd0);
    chk("rst_y1",   32'(y1),   32'd0);
    chk("rst_y2",   32'(y2),   32'd0);
    chk("rst_cnt",  32'(cnt0), 32'd0);
    chk("rst_rdy",  32'(rdy0), 32'd1);
    reset = 1'b0;
    cyc();

    // Single beat through all three mux forms, latency 2
    in_valid = 1'b1; in_a = 16'hF0F0; in_b = 16'hAAAA;
    chk("single_rdy", 32'(rdy0), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("lat1_ov", 32'(ov0), 32'd0);
    cyc();
    chk("lat2_ov",  32'(ov0), 32'd1);
    chk("good_y",   32'(y0),  32'h0000A0A0);
    chk("one_y",    32'(y1),  32'h0000AFAF);
    chk("swap_y",   32'(y2),  32'h00000A0A);
    chk("one_ov",   32'(ov1), 32'd1);
    cyc();
    chk("single_done_ov", 32'(ov0),  32'd0);
    chk("single_cnt",     32'(cnt0), 32'd1);

    // Back-to-back stream of 10 beats from a fresh reset
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    in_a  = 16'hFFFF;
    for (int k = 0; k < 12; k++) begin
      if (k < 10) begin
        in_valid = 1'b1;
        in_b     = 16'(k);
        chk("stream_rdy", 32'(rdy0), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      if (k >= 2) begin
        chk("stream_ov", 32'(ov0), 32'd1);
        chk("stream_y",  32'(y0),  32'(k - 2));
      end
      cyc();
    end
    chk("stream_end_ov", 32'(ov0),  32'd0);
    chk("stream_cnt",    32'(cnt0), 32'd10);

    // Backpressure: three beats offered while out_ready is low
    out_ready = 1'b0;
    in_valid  = 1'b1; in_b = 16'h0011;
    chk("bp_rdy0", 32'(rdy0), 32'd1);
    cyc();
    chk("bp_rdy1", 32'(rdy0), 32'd1);
    in_b = 16'h0022;
    cyc();
    chk("bp_ov",   32'(ov0),  32'd1);
    chk("bp_y",    32'(y0),   32'h0011);
    chk("bp_full", 32'(rdy0), 32'd0);
    in_b = 16'h0033;
    cyc();
    chk("bp_hold_rdy", 32'(rdy0), 32'd0);
    chk("bp_hold_y",   32'(y0),   32'h0011);
    cyc();
    chk("bp_hold_y2",  32'(y0),   32'h0011);
    chk("bp_cnt",      32'(cnt0), 32'd10);
    out_ready = 1'b1;
    #1;
    // Third beat is accepted on the same edge that drains the first.
    chk("bp_release_rdy", 32'(rdy0), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("drain1_ov", 32'(ov0), 32'd1);
    chk("drain1_y",  32'(y0),  32'h0022);
    cyc();
    chk("drain2_ov", 32'(ov0), 32'd1);
    chk("drain2_y",  32'(y0),  32'h0033);
    cyc();
    chk("drain_done_ov", 32'(ov0),  32'd0);
    chk("drain_cnt",     32'(cnt0), 32'd13);

    // Reset with two beats in flight
    in_valid = 1'b1; in_b = 16'h0055;
    cyc();
    in_b = 16'h0066;
    cyc();
    in_valid = 1'b0;
    reset    = 1'b1;
    cyc();
    chk("flush_ov",  32'(ov0),  32'd0);
    chk("flush_y",   32'(y0),   32'd0);
    chk("flush_cnt", 32'(cnt0), 32'd0);
    chk("flush_rdy", 32'(rdy0), 32'd1);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("flush_no_stale", 32'(ov0), 32'd0);
    end

    // Saturation: continuous stream, count reaches 16'hFFFF and holds there
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h1234;
    repeat (65536) cyc();
    chk("sat_pre",  32'(cnt0), 32'h0000FFFE);
    cyc();
    chk("sat_max",  32'(cnt0), 32'h0000FFFF);
    repeat (5) cyc();
    chk("sat_hold", 32'(cnt0), 32'h0000FFFF);
    chk("sat_ov",   32'(ov0),  32'd1);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_and_mux_pipe_array
`default_nettype wire
